pcore_soc_top: RTL and testbench

Memory-mapped subsystem of the PCore SoC, driven by the single external debug port acting as bus master. A write decoder feeds the main memory, two 8N1 UART transmitters, an SPI master, an interrupt-pending register and the compliance signature/halt strobes. It is the top-level block instantiated by the simulation bench and by the FPGA wrapper. Benches inspect its internal state through fixed hierarchical names.

---
 rtl/pcore_soc_top.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pcore_soc_top.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcore_soc_top.sv
// PCore SoC memory-mapped subsystem. The debug port is the bus master.
// Writes go to main memory, two UART TX units, an SPI master, irq_pending and the signature/halt strobes.
// Ports: clk, rst_n (async, active-high), irq_ext_i, irq_soft_i, uart_rxd_i (ignored),
//        uart_txd_o, spi_clk_o, spi_cs_o, spi_miso_i, spi_mosi_o, debug_port_i.
// Optional feature macro: PCORE_UART_NS_EN adds uart_ns_module at 0x9001_0000.
package pcore_pkg;
    typedef struct packed {
        logic [31:0] reg_addr;
        logic [31:0] reg_data;
        logic        reg_wr_req;
    } type_debug_port_s;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
    } type_dbus_s;
endpackage

// 8N1 transmitter. Holds the clocks-per-bit register.
// The register is clamped to a minimum of 2 when written.
module pcore_uart_tx #(
    parameter int unsigned DIV_RST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_data_i,
    input  logic        wr_div_i,
    input  logic [15:0] wdata_i,
    output logic        txd_o
);
    logic [7:0]  uart_reg_tx_ff;
    logic        tx_valid_ff;
    logic        busy_q;
    logic        txd_q;
    logic [8:0]  sh_q;
    logic [3:0]  bit_q;
    logic [15:0] div_q;
    logic [15:0] cnt_q;
    logic        start;

    assign start = wr_data_i & ~busy_q;
    assign txd_o = txd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_reg_tx_ff <= '0;
            tx_valid_ff    <= 1'b0;
            busy_q         <= 1'b0;
            txd_q          <= 1'b1;
            sh_q           <= '1;
            bit_q          <= '0;
            div_q          <= 16'(DIV_RST);
            cnt_q          <= '0;
        end else begin
            tx_valid_ff <= start;
            if (wr_div_i)
                div_q <= (wdata_i < 16'd2) ? 16'd2 : wdata_i;
            if (start) begin
                // Start bit is driven immediately; the 9 remaining bits are data + stop.
                uart_reg_tx_ff <= wdata_i[7:0];
                sh_q           <= {1'b1, wdata_i[7:0]};
                bit_q          <= 4'd9;
                cnt_q          <= div_q - 16'd1;
                txd_q          <= 1'b0;
                busy_q         <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q != 16'd0) begin
                    cnt_q <= cnt_q - 16'd1;
                end else if (bit_q == 4'd0) begin
                    busy_q <= 1'b0;
                end else begin
                    txd_q <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[8:1]};
                    bit_q <= bit_q - 4'd1;
                    cnt_q <= div_q - 16'd1;
                end
            end
        end
    end
endmodule

// Word array with one read/write port. Contents are deliberately not reset.
module pcore_main_mem #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] dualport_memory [WORDS];

    always_ff @(posedge clk) begin
        if (we_i)
            dualport_memory[addr_i] <= wdata_i;
        rdata_o <= dualport_memory[addr_i];
    end
endmodule

module pcore_mem_top #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    pcore_main_mem #(.WORDS(WORDS), .AW(AW)) main_mem_module (
        .clk(clk), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o)
    );
endmodule

module pcore_soc_top
    import pcore_pkg::*;
#(
    parameter int MEM_WORDS    = 4096,
    parameter int UART_DIV_RST = 16,
    parameter int SPI_DIV_RST  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_ext_i,
    input  logic             irq_soft_i,
    input  logic             uart_rxd_i,
    output logic             uart_txd_o,
    output logic             spi_clk_o,
    output logic             spi_cs_o,
    input  logic             spi_miso_i,
    output logic             spi_mosi_o,
    input  type_debug_port_s debug_port_i
);
    localparam int MEM_AW = $clog2(MEM_WORDS);

    logic        req_q;
    logic        bus_wr;
    type_dbus_s  dbus2peri;
    logic [31:0] wa;
    logic        hit_sig, hit_halt;
    logic        sel_mem, sel_u0_d, sel_u0_v, sel_spi_d, sel_spi_v, sel_irq;
    logic        sig_en;
    logic        halt_flag;
    logic [1:0]  irq_s1_q, irq_s2_q, irq_pending;
    logic [31:0] mem_rdata;
    logic        txd0;

    // Word-aligned view: the two low address bits do not participate.
    assign wa       = {dbus2peri.addr[31:2], 2'b00};
    assign hit_sig  = wa == 32'h8E00_0000;
    assign hit_halt = wa == 32'h8F00_0000;
    assign sel_mem  = bus_wr && wa[31:28] == 4'h8 && !hit_sig && !hit_halt;
    assign sig_en   = bus_wr && hit_sig;
    assign sel_u0_d = bus_wr && wa == 32'h9000_0000;
    assign sel_u0_v = bus_wr && wa == 32'h9000_0004;
    assign sel_spi_d = bus_wr && wa == 32'h9002_0000;
    assign sel_spi_v = bus_wr && wa == 32'h9002_0004;
    assign sel_irq  = bus_wr && wa == 32'h9003_0000;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            req_q     <= 1'b0;
            bus_wr    <= 1'b0;
            dbus2peri <= '0;
        end else begin
            req_q  <= debug_port_i.reg_wr_req;
            bus_wr <= debug_port_i.reg_wr_req & ~req_q;
            if (debug_port_i.reg_wr_req & ~req_q) begin
                dbus2peri.addr   <= debug_port_i.reg_addr;
                dbus2peri.w_data <= debug_port_i.reg_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            halt_flag   <= 1'b0;
            irq_s1_q    <= '0;
            irq_s2_q    <= '0;
            irq_pending <= '0;
        end else begin
            if (bus_wr && hit_halt)
                halt_flag <= 1'b1;
            irq_s1_q <= {irq_soft_i, irq_ext_i};
            irq_s2_q <= irq_s1_q;
            // Set is OR-ed after the clear so a simultaneous set wins.
            irq_pending <= (irq_pending & ~(sel_irq ? dbus2peri.w_data[1:0] : 2'b00))
                         | irq_s2_q;
        end
    end

    pcore_mem_top #(.WORDS(MEM_WORDS), .AW(MEM_AW)) mem_top_module (
        .clk(clk), .we_i(sel_mem),
        .addr_i(dbus2peri.addr[MEM_AW+1:2]),
        .wdata_i(dbus2peri.w_data), .rdata_o(mem_rdata)
    );

    pcore_uart_tx #(.DIV_RST(UART_DIV_RST)) uart_module (
        .clk(clk), .rst(rst_n), .wr_data_i(sel_u0_d), .wr_div_i(sel_u0_v),
        .wdata_i(dbus2peri.w_data[15:0]), .txd_o(txd0)
    );

`ifdef PCORE_UART_NS_EN
    logic txd_ns;
    logic sel_ns_d, sel_ns_v;
    assign sel_ns_d = bus_wr && wa == 32'h9001_0000;
    assign sel_ns_v = bus_wr && wa == 32'h9001_0004;

    pcore_uart_tx #(.DIV_RST(UART_DIV_RST)) uart_ns_module (
        .clk(clk), .rst(rst_n), .wr_data_i(sel_ns_d), .wr_div_i(sel_ns_v),
        .wdata_i(dbus2peri.w_data[15:0]), .txd_o(txd_ns)
    );
    assign uart_txd_o = txd0 & txd_ns;
`else
    assign uart_txd_o = txd0;
`endif

    // SPI mode 0: phase counter 0..15 alternates rising/falling edges,
    // phase 16 is the trailing half-period before chip select releases.
    logic        spi_busy_q, spi_clk_q, spi_cs_q, spi_mosi_q;
    logic [7:0]  spi_sh_q, spi_rx_ff;
    logic [4:0]  spi_ph_q;
    logic [15:0] spi_cnt_q, spi_div_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            spi_busy_q <= 1'b0;
            spi_clk_q  <= 1'b0;
            spi_cs_q   <= 1'b1;
            spi_mosi_q <= 1'b0;
            spi_sh_q   <= '0;
            spi_rx_ff  <= '0;
            spi_ph_q   <= '0;
            spi_cnt_q  <= '0;
            spi_div_q  <= 16'(SPI_DIV_RST);
        end else begin
            if (sel_spi_v)
                spi_div_q <= (dbus2peri.w_data[15:0] == 16'd0) ? 16'd1 : dbus2peri.w_data[15:0];
            if (sel_spi_d && !spi_busy_q) begin
                spi_busy_q <= 1'b1;
                spi_cs_q   <= 1'b0;
                spi_clk_q  <= 1'b0;
                spi_mosi_q <= dbus2peri.w_data[7];
                spi_sh_q   <= dbus2peri.w_data[7:0];
                spi_ph_q   <= '0;
                spi_cnt_q  <= spi_div_q - 16'd1;
            end else if (spi_busy_q) begin
                if (spi_cnt_q != 16'd0) begin
                    spi_cnt_q <= spi_cnt_q - 16'd1;
                end else begin
                    spi_cnt_q <= spi_div_q - 16'd1;
                    spi_ph_q  <= spi_ph_q + 5'd1;
                    if (spi_ph_q == 5'd16) begin
                        spi_cs_q   <= 1'b1;
                        spi_busy_q <= 1'b0;
                        spi_mosi_q <= 1'b0;
                    end else if (!spi_ph_q[0]) begin
                        spi_clk_q <= 1'b1;
                        spi_rx_ff <= {spi_rx_ff[6:0], spi_miso_i};
                    end else begin
                        spi_clk_q  <= 1'b0;
                        spi_sh_q   <= {spi_sh_q[6:0], 1'b0};
                        spi_mosi_q <= spi_sh_q[6];
                    end
                end
            end
        end
    end

    assign spi_clk_o  = spi_clk_q;
    assign spi_cs_o   = spi_cs_q;
    assign spi_mosi_o = spi_mosi_q;

    logic unused_bits;
    assign unused_bits = ^{uart_rxd_i, dbus2peri.addr[1:0], mem_rdata};
endmodule

// File: tb/tb_pcore_soc_top.sv
// Directed bench for pcore_soc_top: memory, strobes, IRQ, UART and SPI.
// Expected values are hand-computed constants.
module tb_pcore_soc_top;
    import pcore_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             irq_ext_i, irq_soft_i, uart_rxd_i;
    logic             uart_txd_o, spi_clk_o, spi_cs_o, spi_miso_i, spi_mosi_o;
    type_debug_port_s debug_port_i;

    int vecs = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    pcore_soc_top dut (
        .clk(clk), .rst_n(rst_n), .irq_ext_i(irq_ext_i), .irq_soft_i(irq_soft_i),
        .uart_rxd_i(uart_rxd_i), .uart_txd_o(uart_txd_o), .spi_clk_o(spi_clk_o),
        .spi_cs_o(spi_cs_o), .spi_miso_i(spi_miso_i), .spi_mosi_o(spi_mosi_o),
        .debug_port_i(debug_port_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        debug_port_i = '{a, d, 1'b1};
        tick();
        debug_port_i.reg_wr_req = 1'b0;
    endtask

    // Full 8N1 frame at 16 clocks per bit; t counts cycles from the req rise.
    task automatic uart_frame(input logic [7:0] b, input bit drop);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        bus_write(32'h9000_0000, {24'h0, b});
        for (int t = 1; t <= 163; t++) begin
            if (drop && t == 10)
                debug_port_i = '{32'h9000_0000, 32'h0000_005A, 1'b1};
            if (t == 11)
                debug_port_i.reg_wr_req = 1'b0;
            if (t == 2) begin
                chk("uart_valid", 32'(dut.uart_module.tx_valid_ff), 32'd1);
                chk("uart_reg", 32'(dut.uart_module.uart_reg_tx_ff), 32'(b));
            end
            if (t == 3)
                chk("uart_valid_end", 32'(dut.uart_module.tx_valid_ff), 32'd0);
            if (drop && t == 12) begin
                chk("uart_drop_valid", 32'(dut.uart_module.tx_valid_ff), 32'd0);
                chk("uart_drop_reg", 32'(dut.uart_module.uart_reg_tx_ff), 32'(b));
            end
            if (t >= 2 && t <= 161)
                chk("uart_bit", 32'(uart_txd_o), 32'(fr[(t-2)/16]));
            else
                chk("uart_idle", 32'(uart_txd_o), 32'd1);
            tick();
        end
    endtask

    initial begin
        logic [7:0] bits;
        int pulses;
        int last_fall;
        int cs_up;
        logic prev;

        rst_n = 1'b1;
        irq_ext_i = 1'b0;
        irq_soft_i = 1'b0;
        uart_rxd_i = 1'b1;
        spi_miso_i = 1'b1;
        debug_port_i = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();

        chk("rst_txd", 32'(uart_txd_o), 32'd1);
        chk("rst_sclk", 32'(spi_clk_o), 32'd0);
        chk("rst_cs", 32'(spi_cs_o), 32'd1);
        chk("rst_mosi", 32'(spi_mosi_o), 32'd0);
        chk("rst_halt", 32'(dut.halt_flag), 32'd0);
        chk("rst_irq", 32'(dut.irq_pending), 32'd0);
        chk("rst_udiv", 32'(dut.uart_module.div_q), 32'd16);
        chk("rst_sdiv", 32'(dut.spi_div_q), 32'd2);
        chk("rst_buswr", 32'(dut.bus_wr), 32'd0);
        chk("rst_sig", 32'(dut.sig_en), 32'd0);

        bus_write(32'h8000_000C, 32'h1111_1111);
        tick();
        bus_write(32'h8000_0014, 32'h2222_2222);
        tick();
        bus_write(32'h8000_0010, 32'hDEAD_BEEF);
        chk("bus_wr", 32'(dut.bus_wr), 32'd1);
        chk("bus_addr", dut.dbus2peri.addr, 32'h8000_0010);
        tick();
        chk("mem4", dut.mem_top_module.main_mem_module.dualport_memory[4], 32'hDEAD_BEEF);
        chk("mem3", dut.mem_top_module.main_mem_module.dualport_memory[3], 32'h1111_1111);
        chk("mem5", dut.mem_top_module.main_mem_module.dualport_memory[5], 32'h2222_2222);
        bus_write(32'h8000_4010, 32'hCAFE_F00D);
        tick();
        chk("mem_wrap", dut.mem_top_module.main_mem_module.dualport_memory[4], 32'hCAFE_F00D);
        chk("mem_wrap5", dut.mem_top_module.main_mem_module.dualport_memory[5], 32'h2222_2222);
        bus_write(32'h8000_0000, 32'hA0A0_A0A0);
        tick();

        bus_write(32'h8E00_0000, 32'h0000_1234);
        chk("sig_en", 32'(dut.sig_en), 32'd1);
        chk("sig_data", dut.dbus2peri.w_data, 32'h0000_1234);
        tick();
        chk("sig_en_end", 32'(dut.sig_en), 32'd0);
        chk("halt_pre", 32'(dut.halt_flag), 32'd0);
        chk("sig_mem0", dut.mem_top_module.main_mem_module.dualport_memory[0], 32'hA0A0_A0A0);
        bus_write(32'h8F00_0000, 32'h0000_0000);
        tick();
        chk("halt", 32'(dut.halt_flag), 32'd1);
        chk("halt_mem0", dut.mem_top_module.main_mem_module.dualport_memory[0], 32'hA0A0_A0A0);
        bus_write(32'hA000_0000, 32'hFFFF_FFFF);
        tick();
        chk("unmapped_mem0", dut.mem_top_module.main_mem_module.dualport_memory[0], 32'hA0A0_A0A0);
        chk("halt_sticky", 32'(dut.halt_flag), 32'd1);
`ifndef PCORE_UART_NS_EN
        bus_write(32'h9001_0000, 32'h0000_0000);
        repeat (3) tick();
        chk("ns_absent_txd", 32'(uart_txd_o), 32'd1);
`endif

        irq_ext_i = 1'b1;
        tick();
        irq_ext_i = 1'b0;
        tick();
        chk("irq_lat2", 32'(dut.irq_pending), 32'd0);
        tick();
        chk("irq_lat3", 32'(dut.irq_pending), 32'd1);
        bus_write(32'h9003_0000, 32'h0000_0001);
        tick();
        chk("irq_clr", 32'(dut.irq_pending), 32'd0);
        irq_ext_i = 1'b1;
        repeat (3) tick();
        chk("irq_hold", 32'(dut.irq_pending), 32'd1);
        bus_write(32'h9003_0000, 32'h0000_0001);
        tick();
        chk("irq_set_wins", 32'(dut.irq_pending), 32'd1);
        irq_ext_i = 1'b0;
        repeat (3) tick();
        bus_write(32'h9003_0000, 32'h0000_0001);
        tick();
        chk("irq_clr2", 32'(dut.irq_pending), 32'd0);
        irq_soft_i = 1'b1;
        tick();
        irq_soft_i = 1'b0;
        tick();
        tick();
        chk("irq_soft", 32'(dut.irq_pending), 32'd2);
        bus_write(32'h9003_0000, 32'h0000_0002);
        tick();
        chk("irq_soft_clr", 32'(dut.irq_pending), 32'd0);

        uart_frame(8'h41, 1'b1);

        bus_write(32'h9000_0004, 32'h0000_0001);
        tick();
        chk("udiv_clamp", 32'(dut.uart_module.div_q), 32'd2);
        bus_write(32'h9000_0004, 32'h0000_0010);
        tick();
        chk("udiv_16", 32'(dut.uart_module.div_q), 32'd16);

        bus_write(32'h9000_0000, 32'h0000_0055);
        tick();
        tick();
        tick();
        chk("uart_mid_start", 32'(uart_txd_o), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("uart_rst_txd", 32'(uart_txd_o), 32'd1);
        chk("uart_rst_valid", 32'(dut.uart_module.tx_valid_ff), 32'd0);
        chk("rst_halt_clr", 32'(dut.halt_flag), 32'd0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("uart_post_rst", 32'(uart_txd_o), 32'd1);
        uart_frame(8'hC3, 1'b0);

        spi_miso_i = 1'b1;
        bits = '0;
        pulses = 0;
        last_fall = -1;
        cs_up = -1;
        prev = 1'b0;
        bus_write(32'h9002_0000, 32'h0000_00A5);
        tick();
        chk("spi_cs_low", 32'(spi_cs_o), 32'd0);
        for (int t = 2; t < 100 && cs_up < 0; t++) begin
            if (spi_clk_o && !prev) begin
                bits = {bits[6:0], spi_mosi_o};
                pulses++;
            end
            if (!spi_clk_o && prev)
                last_fall = t;
            if (spi_cs_o)
                cs_up = t;
            prev = spi_clk_o;
            tick();
        end
        chk("spi_done", 32'(cs_up > 0), 32'd1);
        chk("spi_pulses", 32'(pulses), 32'd8);
        chk("spi_mosi", 32'(bits), 32'h0000_00A5);
        chk("spi_rx", 32'(dut.spi_rx_ff), 32'h0000_00FF);
        chk("spi_cs_tail", 32'(cs_up - last_fall), 32'd2);
        chk("spi_cs_high", 32'(spi_cs_o), 32'd1);
        chk("spi_sclk_idle", 32'(spi_clk_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule
